// File: rtl/level0_fifo_ctrl.sv
// rtl/level0_fifo_ctrl.sv - in-order FIFO controller over a single-port registered-read RAM
//
// Purpose:
//    Entries accepted on the upstream handshake are written into an external
//    single-port RAM and read back in order into a 2-entry output buffer
//    (obuf) that feeds the downstream handshake. At most one RAM access
//    (write or read) is issued per cycle. The RAM returns read data one cycle
//    after the read is issued; that cycle is tracked by the inflight flag.
//
// Ports:
//    clk        - single clock, all state on the rising edge
//    rst_n      - synchronous active-low reset
//    in_valid   - upstream entry valid
//    in_ready   - upstream entry accepted when in_valid && in_ready
//    in_data    - upstream entry
//    out_valid  - downstream entry valid (obuf non-empty)
//    out_ready  - downstream consumes when out_valid && out_ready
//    out_data   - obuf head entry
//    count      - entries held: RAM + in-flight + obuf (0..depth+2)
//    mem_cen_n  - RAM enable, active-low
//    mem_wen    - RAM write enable, active-high
//    mem_addr   - RAM address (0 when idle)
//    mem_wdata  - RAM write data (always in_data)
//    mem_rdata  - RAM read data, valid the cycle after a read issue

module level0_fifo_ctrl #(
   parameter int data_width = 48,
   parameter int addr_width = 4,
   parameter int depth      = 10
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [data_width-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [data_width-1:0] out_data,
   output logic [3:0]            count,
   output logic                  mem_cen_n,
   output logic                  mem_wen,
   output logic [addr_width-1:0] mem_addr,
   output logic [data_width-1:0] mem_wdata,
   input  logic [data_width-1:0] mem_rdata
);

   localparam int                    cnt_width = addr_width + 1;
   localparam logic [addr_width-1:0] last_ptr  = addr_width'(depth - 1);
   localparam logic [cnt_width-1:0]  full_cnt  = cnt_width'(depth);

   logic [addr_width-1:0] wr_ptr;
   logic [addr_width-1:0] rd_ptr;
   logic [cnt_width-1:0]  ram_cnt;
   logic [data_width-1:0] obuf [2];
   logic [1:0]            obuf_occ;
   logic                  inflight;

   logic       full;
   logic [1:0] pending;
   logic       read_req;
   logic       read_prio;
   logic       do_write;
   logic       do_read;
   logic       do_pop;
   logic       cap_idx;

   // Control is derived from registered state only, so in_ready never
   // depends on in_valid and there is no combinational loop upstream.
   always_comb begin
      full      = (ram_cnt == full_cnt);
      // obuf slots already spoken for: held entries plus the read on its way
      pending   = obuf_occ + {1'b0, inflight};
      read_req  = (ram_cnt != '0) && (pending < 2'd2);
      // With nothing buffered or in flight, the read is urgent and wins the
      // RAM port; otherwise writes win and reads fill in idle cycles.
      read_prio = read_req && (obuf_occ == 2'd0) && !inflight;
      in_ready  = rst_n && !full && !read_prio;
      do_write  = in_valid && in_ready;
      do_read   = rst_n && read_req && !do_write;
      out_valid = (obuf_occ != 2'd0);
      out_data  = obuf[0];
      do_pop    = out_valid && out_ready;
      // Returning read data lands behind whatever survives this cycle's pop.
      cap_idx   = ((obuf_occ - {1'b0, do_pop}) != 2'd0);

      mem_cen_n = !(do_write || do_read);
      mem_wen   = do_write;
      mem_wdata = in_data;
      if (do_write) begin
         mem_addr = wr_ptr;
      end else if (do_read) begin
         mem_addr = rd_ptr;
      end else begin
         mem_addr = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         ram_cnt  <= '0;
         obuf_occ <= 2'd0;
         inflight <= 1'b0;
         count    <= 4'd0;
         obuf[0]  <= '0;
         obuf[1]  <= '0;
      end else begin
         if (do_write) begin
            wr_ptr <= (wr_ptr == last_ptr) ? '0 : wr_ptr + 1'b1;
         end
         if (do_read) begin
            rd_ptr <= (rd_ptr == last_ptr) ? '0 : rd_ptr + 1'b1;
         end

         // Write and read are mutually exclusive on the single RAM port.
         if (do_write) begin
            ram_cnt <= ram_cnt + 1'b1;
         end else if (do_read) begin
            ram_cnt <= ram_cnt - 1'b1;
         end

         inflight <= do_read;

         // Reads and captures only move entries between internal stages,
         // so the total changes only on the external handshakes.
         if (do_write && !do_pop) begin
            count <= count + 4'd1;
         end else if (do_pop && !do_write) begin
            count <= count - 4'd1;
         end

         // Shift on pop; a capture in the same cycle is issued after the
         // shift so it overrides slot 0 when that is where it belongs.
         if (do_pop) begin
            obuf[0] <= obuf[1];
         end
         if (inflight) begin
            obuf[cap_idx] <= mem_rdata;
         end
         obuf_occ <= obuf_occ + {1'b0, inflight} - {1'b0, do_pop};
      end
   end

endmodule
